uart_transceiver: RTL and testbench
===================================

Name: uart_transceiver

Overview:
Full-duplex 8-bit UART with a transmitter and a receiver that share one clock, one baud-rate selector and one parity selector. TX serialises a parallel byte into a frame: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit. RX deserialises a frame using 16x oversampling and flags each received byte. It sits between a byte-level host and the serial pins. For loopback, the tx_out pin can be wired externally to rx_in.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive baud divisors.
OVERSAMPLE, 16, RX samples per bit; TX bit period = OVERSAMPLE ticks.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200 baud
parity_type  input  2  00=none, 01=odd, 10=even, 11=none
tx_enable  input  1  level request to transmit tx_din
tx_din  input  8  byte to transmit
tx_sending  output  1  high while a TX frame is in progress
tx_out  output  1  serial TX line, idle high
rx_in  input  1  serial RX line, idle high
rx_data  output  8  last received byte
rx_parity_bit  output  1  parity bit received in last frame (0 if parity disabled)
rx_parity_err  output  1  last frame parity mismatch (0 if parity disabled)
recieve_flag  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (reset=0, async): tx_out=1, tx_sending=0, rx_data=0, rx_parity_bit=0, rx_parity_err=0, recieve_flag=0. All FSMs go to IDLE and all counters clear.
- Tick generator: free-running counter. It emits a 1-cycle tick every DIV clocks, with DIV = round(CLK_FREQ/(baud*OVERSAMPLE)); at 50 MHz DIV = 1302/651/326/163. One bit time = 16 ticks. A baud_rate change reloads the divisor immediately. Changing baud_rate or parity_type mid-frame corrupts that frame; the host changes them only when idle.
- Parity: odd makes the count of ones in data+parity odd; even makes it even.
- TX FSM states: IDLE -> START -> DATA(8) -> PARITY (skipped when none) -> STOP -> IDLE.
  - In IDLE with tx_enable=1, it latches tx_din and parity_type, sets tx_sending=1 the next cycle and drives tx_out=0. It aligns to the next bit boundary, at most 1 tick late.
  - Each state lasts 16 ticks.
  - tx_sending drops to 0 after the stop bit completes.
  - If tx_enable is still 1 at that point, the next frame starts immediately, back-to-back. tx_din changes during a frame have no effect.
- RX FSM states: IDLE -> START -> DATA -> PARITY (when enabled) -> STOP -> IDLE.
  - rx_in passes through a 2-flop synchroniser before use.
  - IDLE: a falling level (0) moves to START.
  - START: re-sample at tick 8. If rx_in is 1, the start is false and the FSM returns to IDLE with no flag.
  - Data bits are sampled every 16 ticks thereafter at mid-bit and shifted in LSB first. Parity is sampled the same way when enabled.
  - STOP: sampled at mid-bit. rx_data, rx_parity_bit and rx_parity_err update together, and recieve_flag pulses high for exactly 1 clk, whether stop is 1 or 0 (no framing-error output).
  - Outputs hold their values until the next completed frame.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame: aborts immediately, tx_out returns to 1, and no flag is produced.

Decomposition:
- Shared package uart_pkg holds:
  - baud code constants
  - parity enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - TX/RX state enums
  - a function computing DIV from CLK_FREQ and the baud code
- One natural sub-module: uart_baud_gen, instantiated once, feeding ticks to both FSMs.
- The TX and RX FSMs live in the top.

Test Plan:
- Reset: hold reset=0 for 200 ns -> tx_out=1, tx_sending=0, rx_data=0, recieve_flag=0.
- Loopback, 2400 baud, odd parity, tx_din=8'hA4, tx_enable high for 100 us (CLK_FREQ=50 MHz):
  - tx_out carries 0, 0,0,1,0,0,1,0,1, parity 0, 1, each bit 20832 clk.
  - recieve_flag pulses once; rx_data=8'hA4, rx_parity_bit=0, rx_parity_err=0.
- Same with parity_type=10 (even) -> parity bit 1; with 00 -> 10-bit frame and rx_parity_bit=0.
- Baud 11 (19200), tx_din=8'h55, no parity -> bit period 2608 clk; rx_data=8'h55.
- Corrupted parity: drive rx_in with 8'hA4, odd parity, parity bit forced 1 -> rx_parity_err=1, rx_data=8'hA4.
- Glitch: rx_in low for 4 ticks only -> no recieve_flag, RX back in IDLE. A reset asserted mid-TX-frame -> tx_out=1 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types, baud codes and helpers.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // 2'b11 is an alias for "no parity".
  function automatic parity_e parity_decode(input logic [1:0] code);
    case (code)
      2'b01:   return PAR_ODD;
      2'b10:   return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

  // Parity bit that makes data+parity odd (PAR_ODD) or even (otherwise).
  function automatic logic parity_calc(input logic [7:0] d, input parity_e p);
    return (p == PAR_ODD) ? ~^d : ^d;
  endfunction

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned os,
                                           input logic [1:0]  code);
    int unsigned rate, den, div;
    rate = 32'd2400 << code;
    den  = rate * os;
    div  = (clk_freq + den / 2) / den;
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator shared by TX and RX.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] baud_rate_i,
  output logic       tick_o
);

  localparam int unsigned DIV0 = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_2400);
  localparam int unsigned DIV1 = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_4800);
  localparam int unsigned DIV2 = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_9600);
  localparam int unsigned DIV3 = baud_div(CLK_FREQ, OVERSAMPLE, BAUD_19200);
  // Slowest rate has the largest divisor; counter runs 0..DIV-1.
  localparam int CNT_W = (DIV0 > 1) ? $clog2(DIV0) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, last;
  logic [1:0]       baud_q;
  logic             baud_chg;

  assign baud_chg = (baud_rate_i != baud_q);
  assign tick_o   = (cnt_q == last) && !baud_chg;

  // Terminal count for the currently loaded rate.
  always_comb begin
    case (baud_q)
      BAUD_2400:  last = CNT_W'(DIV0 - 1);
      BAUD_4800:  last = CNT_W'(DIV1 - 1);
      BAUD_9600:  last = CNT_W'(DIV2 - 1);
      default:    last = CNT_W'(DIV3 - 1);
    endcase
  end

  // Free-running count; a rate change restarts it from zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (baud_chg || cnt_q == last) cnt_d = '0;
  end

  // Counter and loaded-rate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      baud_q <= BAUD_2400;
    end else begin
      cnt_q  <= cnt_d;
      baud_q <= baud_rate_i;
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1/8O1/8E1 UART: TX serialiser and 16x oversampling RX.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] baud_rate,
  input  logic [1:0] parity_type,
  input  logic       tx_enable,
  input  logic [7:0] tx_din,
  output logic       tx_sending,
  output logic       tx_out,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_parity_bit,
  output logic       rx_parity_err,
  output logic       recieve_flag
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

  logic tick;

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clk         (clk),
    .rst_n       (reset),
    .baud_rate_i (baud_rate),
    .tick_o      (tick)
  );

  // ---------------------------------------------------------------- TX
  tx_state_e       tx_state_q, tx_state_d;
  logic [OS_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_data_q, tx_data_d;
  parity_e         tx_par_q, tx_par_d;
  logic            tx_bit_done;

  assign tx_bit_done = tick && (tx_cnt_q == OS_LAST);

  // TX state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_data_q  <= '0;
      tx_par_q   <= PAR_NONE;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_data_q  <= tx_data_d;
      tx_par_q   <= tx_par_d;
    end
  end

  // TX next state: each bit lasts OVERSAMPLE ticks; the start bit absorbs
  // the phase of the free-running tick so later bits are tick-aligned.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_data_d  = tx_data_q;
    tx_par_d   = tx_par_q;
    if (tick && tx_state_q != TX_IDLE) tx_cnt_d = tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_enable) begin
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_data_d  = tx_din;
          tx_par_d   = parity_decode(parity_type);
        end
      end
      TX_START:  if (tx_bit_done) tx_state_d = TX_DATA;
      TX_DATA: begin
        if (tx_bit_done) begin
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == 3'd7)
            tx_state_d = (tx_par_q == PAR_NONE) ? TX_STOP : TX_PARITY;
        end
      end
      TX_PARITY: if (tx_bit_done) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_bit_done) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
    if (tx_bit_done) tx_cnt_d = '0;
  end

  // TX outputs decoded from state; IDLE (and reset) gives a high line.
  always_comb begin
    tx_out     = 1'b1;
    tx_sending = 1'b1;
    case (tx_state_q)
      TX_IDLE:   tx_sending = 1'b0;
      TX_START:  tx_out     = 1'b0;
      TX_DATA:   tx_out     = tx_data_q[tx_idx_q];
      TX_PARITY: tx_out     = parity_calc(tx_data_q, tx_par_q);
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic [1:0]      rx_sync_q;
  logic            rx_s;
  rx_state_e       rx_state_q, rx_state_d;
  logic [OS_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  parity_e         rx_par_q, rx_par_d;
  logic            rx_pbit_q, rx_pbit_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_pout_q, rx_pout_d;
  logic            rx_perr_q, rx_perr_d;
  logic            rx_flag_q, rx_flag_d;
  logic            rx_sample;

  assign rx_s      = rx_sync_q[1];
  assign rx_sample = tick && (rx_cnt_q == OS_LAST);

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_sync_q <= 2'b11;
    else        rx_sync_q <= {rx_sync_q[0], rx_in};
  end

  // RX state, datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= PAR_NONE;
      rx_pbit_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_pout_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_flag_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_data_q  <= rx_data_d;
      rx_pout_q  <= rx_pout_d;
      rx_perr_q  <= rx_perr_d;
      rx_flag_q  <= rx_flag_d;
    end
  end

  // RX next state: confirm start at half a bit, then sample every full bit
  // so every later sample lands mid-bit. Stop level is not checked.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_pbit_d  = rx_pbit_q;
    rx_data_d  = rx_data_q;
    rx_pout_d  = rx_pout_q;
    rx_perr_d  = rx_perr_q;
    rx_flag_d  = 1'b0;
    if (tick && rx_state_q != RX_IDLE) rx_cnt_d = rx_cnt_q + 1'b1;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_par_d   = parity_decode(parity_type);
          rx_pbit_d  = 1'b0;
        end
      end
      RX_START: begin
        if (tick && rx_cnt_q == OS_MID) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 1'b1;
          if (rx_idx_q == 3'd7)
            rx_state_d = (rx_par_q == PAR_NONE) ? RX_STOP : RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_pbit_d  = rx_s;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_state_d = RX_IDLE;
          rx_data_d  = rx_shift_q;
          rx_pout_d  = rx_pbit_q;
          rx_perr_d  = (rx_par_q != PAR_NONE) &&
                       (rx_pbit_q != parity_calc(rx_shift_q, rx_par_q));
          rx_flag_d  = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_sample) rx_cnt_d = '0;
  end

  // RX outputs come straight from their result registers.
  always_comb begin
    rx_data       = rx_data_q;
    rx_parity_bit = rx_pout_q;
    rx_parity_err = rx_perr_q;
    recieve_flag  = rx_flag_q;
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: loopback frames from a vector
// table, directly driven RX frames, glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_transceiver;

  // Low clock frequency keeps frames short: DIV = 16/8/4/2 clocks per tick.
  localparam int unsigned CLK_FREQ = 614_400;
  localparam int unsigned OS       = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] baud_rate = 2'b00;
  logic [1:0] parity_type = 2'b00;
  logic       tx_enable = 1'b0;
  logic [7:0] tx_din = 8'h00;
  logic       tx_sending, tx_out, rx_in;
  logic [7:0] rx_data;
  logic       rx_parity_bit, rx_parity_err, recieve_flag;
  logic       loop_en = 1'b0;
  logic       rx_drv  = 1'b1;

  assign rx_in = loop_en ? tx_out : rx_drv;

  always #5 clk = ~clk;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS)) dut (
    .clk           (clk),
    .reset         (reset),
    .baud_rate     (baud_rate),
    .parity_type   (parity_type),
    .tx_enable     (tx_enable),
    .tx_din        (tx_din),
    .tx_sending    (tx_sending),
    .tx_out        (tx_out),
    .rx_in         (rx_in),
    .rx_data       (rx_data),
    .rx_parity_bit (rx_parity_bit),
    .rx_parity_err (rx_parity_err),
    .recieve_flag  (recieve_flag)
  );

  typedef struct {
    logic [1:0] baud;
    logic [1:0] par;
    logic [7:0] din;
    logic       exp_pbit;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       perr;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   flags    = 0;

  function automatic int div_of(input logic [1:0] b);
    case (b)
      2'b00:   return 16;
      2'b01:   return 8;
      2'b10:   return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic par_en(input logic [1:0] p);
    return (p == 2'b01) || (p == 2'b10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pb, input logic pe);
    exp_t e;
    e.data = d; e.pbit = pb; e.perr = pe;
    expq.push_back(e);
  endtask

  // Wait (bounded) for the scoreboard to drain, then check it did.
  task automatic drain(input string name, input int d);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200 * d) begin @(negedge clk); n++; end
    chk(name, expq.size(), 0);
    expq.delete();
  endtask

  // Loopback frame: check every serial bit mid-bit and the received byte.
  task automatic tx_frame(input vec_t v);
    int   d, nb, el, tgt, f0;
    logic pen, expb;
    d   = div_of(v.baud);
    pen = par_en(v.par);
    nb  = pen ? 10 : 9;
    baud_rate = v.baud; parity_type = v.par; loop_en = 1'b1;
    repeat (40) @(negedge clk);
    f0 = flags;
    push_exp(v.din, pen ? v.exp_pbit : 1'b0, 1'b0);
    tx_din = v.din; tx_enable = 1'b1;
    el = 0;
    while (tx_out !== 1'b0 && el < 64 * d) begin @(negedge clk); el++; end
    chk("tx_start_seen", tx_out, 1'b0);
    chk("tx_sending_hi", tx_sending, 1'b1);
    repeat (4) @(negedge clk);
    el = 4;
    tx_enable = 1'b0;
    tx_din = ~v.din;               // must not affect the frame in flight
    for (int k = 0; k < nb; k++) begin
      tgt = 16 * d * (k + 1) + 8 * d;
      repeat (tgt - el) @(negedge clk);
      el = tgt;
      if (k < 8)             expb = v.din[k];
      else if (pen && k == 8) expb = v.exp_pbit;
      else                    expb = 1'b1;
      chk($sformatf("tx_bit%0d_din%0h", k, v.din), tx_out, expb);
    end
    drain("rx_frame_done", d);
    repeat (16 * d) @(negedge clk);
    chk("tx_sending_lo", tx_sending, 1'b0);
    chk("tx_idle_hi", tx_out, 1'b1);
    chk("flag_once", flags, f0 + 1);
  endtask

  // Measure the first high pulse after the start bit: one bit = 16*DIV clocks.
  task automatic period_check(input string name, input logic [1:0] baud,
                              input logic [1:0] par, input logic [7:0] din, input logic pb);
    int d, el, n;
    d = div_of(baud);
    baud_rate = baud; parity_type = par; loop_en = 1'b1;
    repeat (40) @(negedge clk);
    push_exp(din, pb, 1'b0);
    tx_din = din; tx_enable = 1'b1;
    el = 0;
    while (tx_out !== 1'b0 && el < 64 * d) begin @(negedge clk); el++; end
    el = 0;
    while (tx_out !== 1'b1 && el < 64 * d) begin
      @(negedge clk); el++;
      if (el == 4) tx_enable = 1'b0;
    end
    tx_enable = 1'b0;
    n = 0;
    while (tx_out !== 1'b0 && n < 64 * d) begin @(negedge clk); n++; end
    chk(name, n, 16 * d);
    drain("rx_after_period", d);
    repeat (32 * d) @(negedge clk);
  endtask

  // Drive an RX frame directly with arbitrary parity bit.
  task automatic rx_send(input logic [1:0] baud, input logic [7:0] din,
                         input logic pen, input logic pbit);
    int d;
    d = div_of(baud);
    loop_en = 1'b0; baud_rate = baud;
    repeat (40) @(negedge clk);
    rx_drv = 1'b0; repeat (16 * d) @(negedge clk);
    for (int k = 0; k < 8; k++) begin rx_drv = din[k]; repeat (16 * d) @(negedge clk); end
    if (pen) begin rx_drv = pbit; repeat (16 * d) @(negedge clk); end
    rx_drv = 1'b1; repeat (16 * d) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[8];
    exp_t e;
    int   f0, d;

    vecs[0] = '{2'b00, 2'b01, 8'hA4, 1'b0};   // odd
    vecs[1] = '{2'b00, 2'b10, 8'hA4, 1'b1};   // even
    vecs[2] = '{2'b00, 2'b00, 8'hA4, 1'b0};   // none
    vecs[3] = '{2'b11, 2'b00, 8'h55, 1'b0};
    vecs[4] = '{2'b01, 2'b10, 8'h01, 1'b1};
    vecs[5] = '{2'b10, 2'b01, 8'h00, 1'b1};
    vecs[6] = '{2'b11, 2'b11, 8'hFF, 1'b0};   // code 11 = none
    vecs[7] = '{2'b10, 2'b10, 8'hFF, 1'b0};

    // Watchdog: any stuck wait ends the run.
    fork
      begin
        #900_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
      end
    join_none

    // Scoreboard consumer: every flag pops one expectation.
    fork
      forever begin
        @(negedge clk);
        if (recieve_flag === 1'b1) begin
          flags++;
          if (expq.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_flag actual=%0h required=none", rx_data);
          end else begin
            e = expq.pop_front();
            chk("rx_data", rx_data, e.data);
            chk("rx_parity_bit", rx_parity_bit, e.pbit);
            chk("rx_parity_err", rx_parity_err, e.perr);
          end
          @(negedge clk);
          chk("flag_one_cycle", recieve_flag, 1'b0);
        end
      end
    join_none

    // Reset state.
    #1 reset = 1'b0;
    #200;
    chk("rst_tx_out", tx_out, 1'b1);
    chk("rst_tx_sending", tx_sending, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_parity_bit", rx_parity_bit, 1'b0);
    chk("rst_rx_parity_err", rx_parity_err, 1'b0);
    chk("rst_flag", recieve_flag, 1'b0);
    @(negedge clk) reset = 1'b1;

    // Loopback vector table.
    for (int i = 0; i < 8; i++) tx_frame(vecs[i]);

    // Exact bit periods at the extreme rates.
    period_check("bit_period_19200", 2'b11, 2'b00, 8'h55, 1'b0);
    period_check("bit_period_2400",  2'b00, 2'b01, 8'hA4, 1'b0);

    // Directly driven frames, good and corrupted parity.
    parity_type = 2'b01;
    push_exp(8'hA4, 1'b1, 1'b1);
    rx_send(2'b00, 8'hA4, 1'b1, 1'b1);
    drain("rx_bad_odd", 16);
    parity_type = 2'b10;
    push_exp(8'h3C, 1'b0, 1'b0);
    rx_send(2'b10, 8'h3C, 1'b1, 1'b0);
    drain("rx_good_even", 4);
    push_exp(8'h3C, 1'b1, 1'b1);
    rx_send(2'b10, 8'h3C, 1'b1, 1'b1);
    drain("rx_bad_even", 4);

    // Glitch of 4 ticks must not produce a frame; RX then still works.
    parity_type = 2'b00; loop_en = 1'b0; baud_rate = 2'b00;
    d = div_of(2'b00);
    repeat (40) @(negedge clk);
    f0 = flags;
    rx_drv = 1'b0; repeat (4 * d) @(negedge clk);
    rx_drv = 1'b1; repeat (48 * d) @(negedge clk);
    chk("glitch_no_flag", flags, f0);
    push_exp(8'h5A, 1'b0, 1'b0);
    rx_send(2'b00, 8'h5A, 1'b0, 1'b0);
    drain("rx_after_glitch", d);

    // Reset in the middle of a TX start bit.
    baud_rate = 2'b10; parity_type = 2'b01; loop_en = 1'b1;
    d = div_of(2'b10);
    repeat (40) @(negedge clk);
    tx_din = 8'hC3; tx_enable = 1'b1;
    repeat (4 * d) @(negedge clk);
    tx_enable = 1'b0;
    chk("pre_reset_tx_out", tx_out, 1'b0);
    f0 = flags;
    reset = 1'b0;
    #1;
    chk("midframe_reset_tx_out", tx_out, 1'b1);
    chk("midframe_reset_sending", tx_sending, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (200 * d) @(negedge clk);
    chk("midframe_reset_no_flag", flags, f0);
    chk("midframe_reset_rx_data", rx_data, 8'h00);
    chk("midframe_reset_idle", tx_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
